// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed common-anode seven-segment driver with per-frame shadow load and blanking guard.
// Optional leading-zero suppression is compiled in when SEG7_LZ_BLANK_EN is defined.
module seg7_scan_driver #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_in,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_sync
);

  localparam int              CW        = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0]   CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0]   BLANK_END = CW'(BLANK_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    dig_q, dig_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [3:0]    dp_sh_q, dp_sh_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          frame_sync_q, frame_sync_d;

  logic          tick;
  logic          load;
  logic          in_guard;
  logic          lz_sup;
  logic [3:0]    nib;

  function automatic logic [6:0] seg_decode(input logic [3:0] val);
    logic [6:0] s;
    unique case (val)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign tick = (cnt_q == CNT_LAST);
  assign load = tick && (dig_q == 2'd3);
  assign nib  = shadow_q[{dig_q, 2'b00} +: 4];

  // A zero-length guard must not produce a constant-false compare.
  generate
    if (BLANK_CYCLES == 0) begin : g_no_guard
      assign in_guard = 1'b0;
    end else begin : g_guard
      assign in_guard = (cnt_q < BLANK_END);
    end
  endgenerate

`ifdef SEG7_LZ_BLANK_EN
  // A digit is hidden only when it and every digit to its left are zero with no decimal point.
  always_comb begin
    lz_sup = 1'b0;
    unique case (dig_q)
      2'd1:    lz_sup = (shadow_q[15:4]  == 12'h000) && !dp_sh_q[1];
      2'd2:    lz_sup = (shadow_q[15:8]  == 8'h00)   && !dp_sh_q[2];
      2'd3:    lz_sup = (shadow_q[15:12] == 4'h0)    && !dp_sh_q[3];
      default: lz_sup = 1'b0;
    endcase
  end
`else
  assign lz_sup = 1'b0;
`endif

  always_comb begin
    cnt_d        = tick ? '0 : cnt_q + 1'b1;
    dig_d        = tick ? dig_q + 2'd1 : dig_q;
    shadow_d     = shadow_q;
    dp_sh_d      = dp_sh_q;
    frame_sync_d = load;
    an_d         = 4'b1111;
    seg_d        = 7'b1111111;
    dp_d         = 1'b1;

    if (load) begin
      shadow_d = data_in;
      dp_sh_d  = dp_in;
    end

    if (!in_guard && !lz_sup) begin
      an_d  = ~(4'b0001 << dig_q);
      seg_d = seg_decode(nib);
      dp_d  = ~dp_sh_q[dig_q];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q        <= '0;
      dig_q        <= 2'd0;
      shadow_q     <= 16'h0000;
      dp_sh_q      <= 4'h0;
      an_q         <= 4'b1111;
      seg_q        <= 7'b1111111;
      dp_q         <= 1'b1;
      frame_sync_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      dig_q        <= dig_d;
      shadow_q     <= shadow_d;
      dp_sh_q      <= dp_sh_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_sync_q <= frame_sync_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_sync = frame_sync_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized bench for seg7_scan_driver against a cycle-count-based display model.
module tb_seg7_scan_driver;

  localparam int RD = 8;
  localparam int BC = 2;
  localparam int FR = 4 * RD;
  localparam logic [12:0] BLANK_OUT = 13'b1111_1111111_1_0;

  logic        clk;
  logic        rst;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_sync;

  int          vectors = 0;
  int          errors  = 0;
  int          n       = 0;
  logic [15:0] m_sh    = 16'h0;
  logic [3:0]  m_dp    = 4'h0;

  logic [6:0] seg_lut [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  seg7_scan_driver #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_sync (frame_sync)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

`ifdef SEG7_LZ_BLANK_EN
  function automatic bit lz_hidden(int d);
    return (d != 0) && ((m_sh >> (4 * d)) == 16'h0) && !m_dp[d];
  endfunction
`endif

  // Output after edge n shows the scan position reached after n-1 edges since release.
  task automatic advance(output logic [12:0] e);
    logic [15:0] cap_d;
    logic [3:0]  cap_dp;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    bit          hide;
    int          s, c, d;
    @(posedge clk);
    cap_d  = data_in;
    cap_dp = dp_in;
    n++;
    s = n - 1;
    c = s % RD;
    d = (s / RD) % 4;
`ifdef SEG7_LZ_BLANK_EN
    hide = lz_hidden(d);
`else
    hide = 1'b0;
`endif
    e_an  = 4'hF;
    e_seg = 7'h7F;
    e_dp  = 1'b1;
    if (c >= BC && !hide) begin
      e_an[d] = 1'b0;
      e_seg   = seg_lut[m_sh[4*d +: 4]];
      e_dp    = ~m_dp[d];
    end
    e = {e_an, e_seg, e_dp, (n % FR == 0)};
    if (n % FR == 0) begin
      m_sh = cap_d;
      m_dp = cap_dp;
    end
    #1;
  endtask

  task automatic align_frame();
    logic [12:0] e;
    while (n % FR != 0) advance(e);
  endtask

  task automatic test_reset();
    logic [12:0] e;
    rst = 1'b1;
    data_in = 16'hBEEF;
    dp_in = 4'hF;
    #2 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      vectors++;
      if ({an, seg, dp, frame_sync} !== BLANK_OUT) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got=%b exp=%b", i, {an, seg, dp, frame_sync}, BLANK_OUT);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    n = 0; m_sh = 16'h0; m_dp = 4'h0;
    for (int i = 0; i < 3 * FR; i++) begin
      advance(e);
      vectors++;
      if ({an, seg, dp, frame_sync} !== e) begin
        errors++;
        $display("FAIL reset_frames edge=%0d got=%b exp=%b", n, {an, seg, dp, frame_sync}, e);
      end
      if (n == FR) begin
        vectors++;
        if (frame_sync !== 1'b1) begin
          errors++;
          $display("FAIL first_frame_sync edge=%0d got=%b exp=1", n, frame_sync);
        end
      end
    end
  endtask

  task automatic test_display();
    logic [12:0] e;
    logic [3:0]  x_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0]  x_seg [4] = '{7'b0001110, 7'b0000000, 7'b0001000, 7'b1111001};
    logic        x_dp  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    int          k;
    align_frame();
    data_in = 16'h1A8F;
    dp_in   = 4'b0100;
    for (int i = 0; i < 2 * FR; i++) begin
      advance(e);
      vectors++;
      if ({an, seg, dp, frame_sync} !== e) begin
        errors++;
        $display("FAIL display edge=%0d got=%b exp=%b", n, {an, seg, dp, frame_sync}, e);
      end
      if (i >= FR && (i % RD) == 4) begin
        k = (i / RD) % 4;
        vectors++;
        if ({an, seg, dp} !== {x_an[k], x_seg[k], x_dp[k]}) begin
          errors++;
          $display("FAIL display_slot%0d got=%b exp=%b", k, {an, seg, dp}, {x_an[k], x_seg[k], x_dp[k]});
        end
      end
    end
  endtask

  task automatic test_tearing();
    logic [12:0] e;
    align_frame();
    data_in = 16'h1111;
    dp_in   = 4'h0;
    for (int i = 0; i < FR; i++) advance(e);
    for (int i = 0; i < 3 * FR; i++) begin
      if (i == RD + 3) data_in = 16'h2222;
      advance(e);
      vectors++;
      if ({an, seg, dp, frame_sync} !== e) begin
        errors++;
        $display("FAIL tearing edge=%0d got=%b exp=%b", n, {an, seg, dp, frame_sync}, e);
      end
      if (i < FR && i > RD + 3 && (i % RD) == 4) begin
        vectors++;
        if (seg !== 7'b1111001) begin
          errors++;
          $display("FAIL tearing_hold edge=%0d got=%b exp=1111001", n, seg);
        end
      end
    end
  endtask

  task automatic test_leading_zeros();
    logic [12:0] e;
    logic [15:0] pats [2] = '{16'h0005, 16'h0000};
    align_frame();
    dp_in = 4'h0;
    for (int p = 0; p < 2; p++) begin
      data_in = pats[p];
      for (int i = 0; i < 2 * FR; i++) begin
        advance(e);
        vectors++;
        if ({an, seg, dp, frame_sync} !== e) begin
          errors++;
          $display("FAIL lz pat=%h edge=%0d got=%b exp=%b", pats[p], n, {an, seg, dp, frame_sync}, e);
        end
        if (p == 0 && i >= FR && (i % RD) == 4 && (i / RD) % 4 == 1) begin
          vectors++;
`ifdef SEG7_LZ_BLANK_EN
          if (an !== 4'b1111) begin
            errors++;
            $display("FAIL lz_slot1_an got=%b exp=1111", an);
          end
`else
          if (seg !== 7'b1000000) begin
            errors++;
            $display("FAIL lz_slot1_seg got=%b exp=1000000", seg);
          end
`endif
        end
      end
    end
  endtask

  task automatic test_random();
    logic [12:0] e;
    for (int i = 0; i < 8 * FR; i++) begin
      if ($urandom_range(3) == 0) data_in = 16'($urandom);
      if ($urandom_range(3) == 0) dp_in = 4'($urandom);
      if ($urandom_range(7) == 0) data_in = data_in & 16'h00FF;
      advance(e);
      vectors++;
      if ({an, seg, dp, frame_sync} !== e) begin
        errors++;
        $display("FAIL random edge=%0d got=%b exp=%b", n, {an, seg, dp, frame_sync}, e);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [12:0] e;
    data_in = 16'hC3D7;
    dp_in   = 4'b1001;
    while (n % FR != 2 * RD + BC + 3) advance(e);
    #2 rst = 1'b0;
    #1;
    vectors++;
    if ({an, seg, dp, frame_sync} !== BLANK_OUT) begin
      errors++;
      $display("FAIL async_reset_blank got=%b exp=%b", {an, seg, dp, frame_sync}, BLANK_OUT);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      vectors++;
      if ({an, seg, dp, frame_sync} !== BLANK_OUT) begin
        errors++;
        $display("FAIL async_reset_hold got=%b exp=%b", {an, seg, dp, frame_sync}, BLANK_OUT);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    n = 0; m_sh = 16'h0; m_dp = 4'h0;
    for (int i = 0; i < FR + RD; i++) begin
      advance(e);
      vectors++;
      if ({an, seg, dp, frame_sync} !== e) begin
        errors++;
        $display("FAIL async_restart edge=%0d got=%b exp=%b", n, {an, seg, dp, frame_sync}, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_display();
    test_tearing();
    test_leading_zeros();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
